// File: rtl/dmi_jtag_dtm.sv
// rtl/dmi_jtag_dtm.sv - JTAG debug transport module bridging a TAP to a RISC-V style DMI
//
// Ports:
//   i_clk, i_reset           system clock, synchronous active-high reset
//   i_tck, i_tms, i_tdi      JTAG pins, asynchronous, oversampled in i_clk
//   o_tdo, o_tdo_en          JTAG data out and its enable (high in Shift-IR/Shift-DR)
//   o_dmi_req_*              DMI request channel (valid/ready, address, data, op 1=read 2=write)
//   i_dmi_rsp_*, o_dmi_rsp_ready  DMI response channel (op 0=ok, 2=failed)
module dmi_jtag_dtm #(
    parameter logic [31:0] P_IDCODE = 32'h1000_0001,
    parameter int          P_ABITS  = 7
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tck,
    input  logic               i_tms,
    input  logic               i_tdi,
    output logic               o_tdo,
    output logic               o_tdo_en,
    output logic               o_dmi_req_valid,
    input  logic               i_dmi_req_ready,
    output logic [P_ABITS-1:0] o_dmi_req_address,
    output logic [31:0]        o_dmi_req_data,
    output logic [1:0]         o_dmi_req_op,
    input  logic               i_dmi_rsp_valid,
    output logic               o_dmi_rsp_ready,
    input  logic [31:0]        i_dmi_rsp_data,
    input  logic [1:0]         i_dmi_rsp_op
);

    localparam int         DMI_W       = P_ABITS + 34;
    localparam logic [4:0] IR_IDCODE   = 5'h01;
    localparam logic [4:0] IR_DTMCS    = 5'h10;
    localparam logic [4:0] IR_DMI      = 5'h11;
    localparam logic [5:0] ABITS_FIELD = 6'(P_ABITS);

    typedef enum logic [3:0] {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
        TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
        TAP_SHIFT_IR, TAP_EXIT1_IR, TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tap_e;

    typedef enum logic [1:0] {
        ENG_IDLE, ENG_REQ, ENG_RSP
    } eng_e;

    logic [1:0]         tck_sync_q, tck_sync_d;
    logic [1:0]         tms_sync_q, tms_sync_d;
    logic [1:0]         tdi_sync_q, tdi_sync_d;
    logic               tck_prev_q, tck_prev_d;
    tap_e               tap_q, tap_d, tap_nxt;
    logic [4:0]         ir_q, ir_d;
    logic [4:0]         ir_shift_q, ir_shift_d;
    logic [DMI_W-1:0]   dr_q, dr_d;
    logic               tdo_q, tdo_d;
    eng_e               eng_q, eng_d;
    logic [1:0]         dmistat_q, dmistat_d;
    logic [P_ABITS-1:0] req_addr_q, req_addr_d;
    logic [31:0]        req_data_q, req_data_d;
    logic [1:0]         req_op_q, req_op_d;
    logic [31:0]        rsp_data_q, rsp_data_d;

    logic               tck_s, tms_s, tdi_s;
    logic               tck_rise, tck_fall;
    logic               busy, shifting;
    logic [P_ABITS-1:0] upd_addr;
    logic [31:0]        upd_data;
    logic [1:0]         upd_op;
    logic [31:0]        dtmcs_cap;

    assign tck_s     = tck_sync_q[1];
    assign tms_s     = tms_sync_q[1];
    assign tdi_s     = tdi_sync_q[1];
    assign tck_rise  = tck_s & ~tck_prev_q;
    assign tck_fall  = ~tck_s & tck_prev_q;
    assign busy      = (eng_q != ENG_IDLE);
    assign shifting  = (tap_q == TAP_SHIFT_DR) || (tap_q == TAP_SHIFT_IR);
    assign upd_addr  = dr_q[DMI_W-1:34];
    assign upd_data  = dr_q[33:2];
    assign upd_op    = dr_q[1:0];
    assign dtmcs_cap = {14'h0, 3'b000, 3'h1, dmistat_q, ABITS_FIELD, 4'h1};

    assign o_tdo             = tdo_q;
    assign o_tdo_en          = shifting;
    assign o_dmi_req_valid   = (eng_q == ENG_REQ);
    assign o_dmi_rsp_ready   = (eng_q == ENG_RSP);
    assign o_dmi_req_address = req_addr_q;
    assign o_dmi_req_data    = req_data_q;
    assign o_dmi_req_op      = req_op_q;

    always_comb begin
        tap_nxt = tap_q;
        case (tap_q)
            TAP_TLR:      tap_nxt = tms_s ? TAP_TLR      : TAP_RTI;
            TAP_RTI:      tap_nxt = tms_s ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   tap_nxt = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   tap_nxt = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: tap_nxt = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: tap_nxt = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: tap_nxt = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: tap_nxt = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   tap_nxt = tms_s ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_IR:   tap_nxt = tms_s ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   tap_nxt = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: tap_nxt = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: tap_nxt = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: tap_nxt = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: tap_nxt = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   tap_nxt = tms_s ? TAP_SEL_DR   : TAP_RTI;
            default:      tap_nxt = TAP_TLR;
        endcase
    end

    always_comb begin
        tck_sync_d = {tck_sync_q[0], i_tck};
        tms_sync_d = {tms_sync_q[0], i_tms};
        tdi_sync_d = {tdi_sync_q[0], i_tdi};
        tck_prev_d = tck_s;
        tap_d      = tck_rise ? tap_nxt : tap_q;
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        dr_d       = dr_q;
        tdo_d      = tdo_q;
        eng_d      = eng_q;
        dmistat_d  = dmistat_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_op_d   = req_op_q;
        rsp_data_d = rsp_data_q;

        // DMI engine handshakes; TAP-driven events below may override.
        // A response is only looked at once RSP is entered, so a stale
        // rsp_valid from the previous transaction cannot be consumed in REQ.
        case (eng_q)
            ENG_REQ: begin
                if (i_dmi_req_ready) eng_d = ENG_RSP;
            end
            ENG_RSP: begin
                if (i_dmi_rsp_valid) begin
                    rsp_data_d = i_dmi_rsp_data;
                    if (i_dmi_rsp_op == 2'd2 && dmistat_q == 2'd0) dmistat_d = 2'd2;
                    eng_d = ENG_IDLE;
                end
            end
            default: eng_d = eng_q;
        endcase

        if (tck_rise) begin
            case (tap_q)
                TAP_CAP_IR:   ir_shift_d = 5'b00001;
                TAP_SHIFT_IR: ir_shift_d = {tdi_s, ir_shift_q[4:1]};
                TAP_UPD_IR:   ir_d = ir_shift_q;
                TAP_CAP_DR: begin
                    case (ir_q)
                        IR_IDCODE: dr_d = {{(DMI_W-32){1'b0}}, P_IDCODE | 32'h1};
                        IR_DTMCS:  dr_d = {{(DMI_W-32){1'b0}}, dtmcs_cap};
                        IR_DMI: begin
                            dr_d = {req_addr_q, rsp_data_q, busy ? 2'd3 : dmistat_q};
                            // dmistat_d is checked so a same-cycle response error is kept
                            if (busy && dmistat_d == 2'd0) dmistat_d = 2'd3;
                        end
                        default:   dr_d = '0;
                    endcase
                end
                TAP_SHIFT_DR: begin
                    case (ir_q)
                        IR_IDCODE, IR_DTMCS: dr_d[31:0] = {tdi_s, dr_q[31:1]};
                        IR_DMI:              dr_d = {tdi_s, dr_q[DMI_W-1:1]};
                        default:             dr_d[0] = tdi_s;
                    endcase
                end
                TAP_UPD_DR: begin
                    if (ir_q == IR_DTMCS) begin
                        if (dr_q[17]) begin
                            dmistat_d = 2'd0;
                            eng_d     = ENG_IDLE;
                        end else if (dr_q[16]) begin
                            dmistat_d = 2'd0;
                        end
                    end else if (ir_q == IR_DMI) begin
                        if (busy) begin
                            if (dmistat_d == 2'd0) dmistat_d = 2'd3;
                        end else if (dmistat_q == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
                            req_addr_d = upd_addr;
                            req_data_d = upd_data;
                            req_op_d   = upd_op;
                            eng_d      = ENG_REQ;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Test-Logic-Reset only touches the TAP side, never the DMI engine.
        if (tap_q == TAP_TLR) ir_d = IR_IDCODE;

        if (!shifting) begin
            tdo_d = 1'b0;
        end else if (tck_fall) begin
            tdo_d = (tap_q == TAP_SHIFT_IR) ? ir_shift_q[0] : dr_q[0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
            tap_q      <= TAP_TLR;
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            dr_q       <= '0;
            tdo_q      <= 1'b0;
            eng_q      <= ENG_IDLE;
            dmistat_q  <= 2'd0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_op_q   <= 2'd0;
            rsp_data_q <= '0;
        end else begin
            tck_sync_q <= tck_sync_d;
            tms_sync_q <= tms_sync_d;
            tdi_sync_q <= tdi_sync_d;
            tck_prev_q <= tck_prev_d;
            tap_q      <= tap_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            dr_q       <= dr_d;
            tdo_q      <= tdo_d;
            eng_q      <= eng_d;
            dmistat_q  <= dmistat_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_op_q   <= req_op_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule
